result_fifo: RTL

- Synchronous FIFO that sits directly downstream of the 8-bit synchronous adder.
- Captures each {sum, valid} result into a buffer and presents it to the consumer over a valid/ready handshake.
- The adder has no backpressure, so the FIFO:
  - absorbs bursts;
  - drops writes when full;
  - reports lost results through a sticky overflow flag.

---
 rtl/result_fifo.sv | 102 ++++++++++
 1 files changed

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - FWFT result buffer behind the adder; RESULT_FIFO_ALMOST_FULL_EN adds almost_full
module result_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
`ifdef RESULT_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_MARGIN = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef RESULT_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rd_en, wr_en, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    rd_en      = out_valid && out_ready;
    wr_en      = in_valid && (!full || rd_en);
    drop       = in_valid && !wr_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef RESULT_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= AF_LEVEL);
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule
